team_button_conditioner: RTL and testbench

TEAM_BUTTON_CONDITIONER -- requirements
Module: team_button_conditioner

---
 rtl/team_button_conditioner.sv | 164 ++++++++++++++++
 tb/tb_team_button_conditioner.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/team_button_conditioner.sv
// team_button_conditioner
//
// Conditions two raw, bouncy, active-low push-buttons (up/down) for team 1.
// It produces clean debounced levels, one-cycle press-edge pulses and a
// free-running movement strobe that paces vertical steps.
//
// Each raw input is first passed through a 2-flop synchronizer.
// It then feeds its own 4-state debounce FSM, so the two paths never interact.
// A new level is accepted only after it has been stable for DEBOUNCE_CYCLES
// synchronized cycles.
//
// Parameters:
//   DEBOUNCE_CYCLES  stable cycles needed to accept a new level (1..2^20-1)
//   STEP_PERIOD      clk cycles between movement strobes       (2..2^20-1)
//
// Ports:
//   clk              system clock, all state on the rising edge
//   rst_n            asynchronous active-low reset
//   raw_vu_n         raw up button, active-low, asynchronous, bouncy
//   raw_vd_n         raw down button, active-low, asynchronous, bouncy
//   team1_vu_button  debounced up level, active-low, registered
//   team1_vd_button  debounced down level, active-low, registered
//   team1_move_tick  one-cycle movement strobe, registered
//   team1_press_evt  one-cycle press pulses, bit1 = up, bit0 = down, registered

module team_button_conditioner #(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int STEP_PERIOD     = 416667
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       raw_vu_n,
  input  logic       raw_vd_n,
  output logic       team1_vu_button,
  output logic       team1_vd_button,
  output logic       team1_move_tick,
  output logic [1:0] team1_press_evt
);

  typedef enum logic [1:0] {
    RELEASED     = 2'd0,
    PRESS_PEND   = 2'd1,
    PRESSED      = 2'd2,
    RELEASE_PEND = 2'd3
  } btn_state_e;

  localparam logic [19:0] DB_LAST   = 20'(DEBOUNCE_CYCLES - 1);
  localparam logic [19:0] TICK_LAST = 20'(STEP_PERIOD - 1);

  // Index 1 is the up button and index 0 is the down button.
  // This matches the bit order of team1_press_evt.
  logic [1:0]  sync1_q, sync1_d;
  logic [1:0]  sync2_q, sync2_d;
  btn_state_e  state_q [2];
  btn_state_e  state_d [2];
  logic [19:0] cnt_q [2];
  logic [19:0] cnt_d [2];
  logic [1:0]  btn_q, btn_d;
  logic [1:0]  evt_q, evt_d;
  logic [19:0] tick_cnt_q, tick_cnt_d;
  logic        tick_q, tick_d;

  always_comb begin
    sync1_d = {raw_vu_n, raw_vd_n};
    sync2_d = sync1_q;
  end

  // The debounce FSMs below exit each pending state on the terminal count.
  // Because of that exit, the 20-bit counters can never wrap.
  // The debounced output is computed from the next state, so the level
  // change is registered on the same edge as the state change.
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i];
      case (state_q[i])
        RELEASED: begin
          if (!sync2_q[i]) begin
            state_d[i] = PRESS_PEND;
            cnt_d[i]   = '0;
          end
        end
        PRESS_PEND: begin
          if (sync2_q[i]) begin
            state_d[i] = RELEASED;
            cnt_d[i]   = '0;
          end else if (cnt_q[i] == DB_LAST) begin
            state_d[i] = PRESSED;
            cnt_d[i]   = '0;
          end else begin
            cnt_d[i] = cnt_q[i] + 20'd1;
          end
        end
        PRESSED: begin
          if (sync2_q[i]) begin
            state_d[i] = RELEASE_PEND;
            cnt_d[i]   = '0;
          end
        end
        RELEASE_PEND: begin
          if (!sync2_q[i]) begin
            state_d[i] = PRESSED;
            cnt_d[i]   = '0;
          end else if (cnt_q[i] == DB_LAST) begin
            state_d[i] = RELEASED;
            cnt_d[i]   = '0;
          end else begin
            cnt_d[i] = cnt_q[i] + 20'd1;
          end
        end
        default: begin
          state_d[i] = RELEASED;
          cnt_d[i]   = '0;
        end
      endcase
      btn_d[i] = !((state_d[i] == PRESSED) || (state_d[i] == RELEASE_PEND));
    end
    // A press pulse fires only on the 1->0 transition of the debounced level.
    evt_d = btn_q & ~btn_d;
  end

  // The movement strobe comes from a free-running period counter.
  // It is registered so that it lands one cycle after the counter reads its last value.
  always_comb begin
    tick_d = (tick_cnt_q == TICK_LAST);
    if (tick_cnt_q == TICK_LAST) begin
      tick_cnt_d = '0;
    end else begin
      tick_cnt_d = tick_cnt_q + 20'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q    <= 2'b11;
      sync2_q    <= 2'b11;
      state_q[0] <= RELEASED;
      state_q[1] <= RELEASED;
      cnt_q[0]   <= '0;
      cnt_q[1]   <= '0;
      btn_q      <= 2'b11;
      evt_q      <= 2'b00;
      tick_cnt_q <= '0;
      tick_q     <= 1'b0;
    end else begin
      sync1_q    <= sync1_d;
      sync2_q    <= sync2_d;
      state_q[0] <= state_d[0];
      state_q[1] <= state_d[1];
      cnt_q[0]   <= cnt_d[0];
      cnt_q[1]   <= cnt_d[1];
      btn_q      <= btn_d;
      evt_q      <= evt_d;
      tick_cnt_q <= tick_cnt_d;
      tick_q     <= tick_d;
    end
  end

  assign team1_vu_button = btn_q[1];
  assign team1_vd_button = btn_q[0];
  assign team1_move_tick = tick_q;
  assign team1_press_evt = evt_q;

endmodule

// File: tb/tb_team_button_conditioner.sv
// tb_team_button_conditioner
//
// Directed bench for team_button_conditioner with DEBOUNCE_CYCLES = 4 and
// STEP_PERIOD = 8.
//
// A per-cycle vector table covers clean press, release, glitch and bounce.
// Hand-written sequences cover asynchronous reset and the movement strobe.
// Outputs are compared as the packed value {vu, vd, tick, evt[1:0]}.

module tb_team_button_conditioner;

  logic       clk;
  logic       rst_n;
  logic       raw_vu_n;
  logic       raw_vd_n;
  logic       team1_vu_button;
  logic       team1_vd_button;
  logic       team1_move_tick;
  logic [1:0] team1_press_evt;

  int compared;
  int mismatched;
  int edge_cnt;

  typedef struct {
    logic       vu_n;
    logic       vd_n;
    logic       exp_vu;
    logic       exp_vd;
    logic [1:0] exp_evt;
    string      name;
  } vec_t;

  vec_t vecs[$];

  team_button_conditioner #(
    .DEBOUNCE_CYCLES(4),
    .STEP_PERIOD    (8)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .raw_vu_n       (raw_vu_n),
    .raw_vd_n       (raw_vd_n),
    .team1_vu_button(team1_vu_button),
    .team1_vd_button(team1_vd_button),
    .team1_move_tick(team1_move_tick),
    .team1_press_evt(team1_press_evt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic add_rows(input int n, input logic vu_n, input logic vd_n,
                          input logic evu, input logic evd, input logic [1:0] evt,
                          input string name);
    vec_t v;
    for (int k = 0; k < n; k++) begin
      v.vu_n    = vu_n;
      v.vd_n    = vd_n;
      v.exp_vu  = evu;
      v.exp_vd  = evd;
      v.exp_evt = evt;
      v.name    = name;
      vecs.push_back(v);
    end
  endtask

  task automatic check_output(input string name, input logic [4:0] exp);
    logic [4:0] act;
    act = {team1_vu_button, team1_vd_button, team1_move_tick, team1_press_evt};
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s at edge %0d: {vu,vd,tick,evt} actual=%b required=%b",
               name, edge_cnt, act, exp);
    end
  endtask

  // Drive inputs, then sample 1 time unit after the next rising edge.
  task automatic apply_stimulus(input logic vu_n, input logic vd_n);
    raw_vu_n = vu_n;
    raw_vd_n = vd_n;
    @(posedge clk);
    #1;
    edge_cnt++;
  endtask

  task automatic release_reset();
    @(negedge clk);
    @(negedge clk);
    rst_n    = 1'b1;
    edge_cnt = 0;
  endtask

  function automatic logic tick_model(input int e);
    return (e > 0) && ((e % 8) == 0);
  endfunction

  initial begin
    compared   = 0;
    mismatched = 0;
    edge_cnt   = 0;
    rst_n      = 1'b0;
    raw_vu_n   = 1'b1;
    raw_vd_n   = 1'b1;

    // Table: each row is applied before one edge and checked after it.
    add_rows(6, 1'b0, 1'b1, 1'b1, 1'b1, 2'b00, "clean_press_wait");
    add_rows(1, 1'b0, 1'b1, 1'b0, 1'b1, 2'b10, "clean_press_edge");
    add_rows(3, 1'b0, 1'b1, 1'b0, 1'b1, 2'b00, "clean_press_hold");
    add_rows(6, 1'b1, 1'b1, 1'b0, 1'b1, 2'b00, "release_wait");
    add_rows(1, 1'b1, 1'b1, 1'b1, 1'b1, 2'b00, "release_edge");
    add_rows(3, 1'b1, 1'b1, 1'b1, 1'b1, 2'b00, "release_idle");
    add_rows(3, 1'b0, 1'b1, 1'b1, 1'b1, 2'b00, "glitch_low");
    add_rows(8, 1'b1, 1'b1, 1'b1, 1'b1, 2'b00, "glitch_after");
    add_rows(2, 1'b1, 1'b0, 1'b1, 1'b1, 2'b00, "bounce_low1");
    add_rows(1, 1'b1, 1'b1, 1'b1, 1'b1, 2'b00, "bounce_high");
    add_rows(6, 1'b1, 1'b0, 1'b1, 1'b1, 2'b00, "bounce_wait");
    add_rows(1, 1'b1, 1'b0, 1'b1, 1'b0, 2'b01, "bounce_edge");
    add_rows(3, 1'b1, 1'b0, 1'b1, 1'b0, 2'b00, "bounce_hold");
    add_rows(6, 1'b1, 1'b1, 1'b1, 1'b0, 2'b00, "vd_release_wait");
    add_rows(3, 1'b1, 1'b1, 1'b1, 1'b1, 2'b00, "vd_release_done");

    #12;
    check_output("reset_state", 5'b11000);
    release_reset();

    foreach (vecs[i]) begin
      apply_stimulus(vecs[i].vu_n, vecs[i].vd_n);
      check_output(vecs[i].name,
                   {vecs[i].exp_vu, vecs[i].exp_vd, tick_model(edge_cnt), vecs[i].exp_evt});
    end

    // Asynchronous reset in the middle of PRESS_PEND.
    for (int e = 1; e <= 4; e++) begin
      apply_stimulus(1'b0, 1'b1);
    end
    #3 rst_n = 1'b0;
    #1 check_output("async_reset_pend", 5'b11000);
    release_reset();
    for (int e = 1; e <= 7; e++) begin
      apply_stimulus(1'b0, 1'b1);
      if (e < 7) check_output("requal1_wait", {1'b1, 1'b1, tick_model(edge_cnt), 2'b00});
      else       check_output("requal1_edge", {1'b0, 1'b1, tick_model(edge_cnt), 2'b10});
    end

    // Asynchronous reset while PRESSED: the output must return to 1 at once.
    apply_stimulus(1'b0, 1'b1);
    apply_stimulus(1'b0, 1'b1);
    #3 rst_n = 1'b0;
    #1 check_output("async_reset_pressed", 5'b11000);
    release_reset();
    for (int e = 1; e <= 8; e++) begin
      apply_stimulus(1'b0, 1'b1);
      if (e < 7)       check_output("requal2_wait", {1'b1, 1'b1, tick_model(edge_cnt), 2'b00});
      else if (e == 7) check_output("requal2_edge", {1'b0, 1'b1, tick_model(edge_cnt), 2'b10});
      else             check_output("requal2_hold", {1'b0, 1'b1, tick_model(edge_cnt), 2'b00});
    end

    // Both buttons held from reset release.
    // The strobe must keep pacing, and both paths must switch on the same cycle.
    rst_n    = 1'b0;
    raw_vu_n = 1'b0;
    raw_vd_n = 1'b0;
    release_reset();
    for (int e = 1; e <= 26; e++) begin
      apply_stimulus(1'b0, 1'b0);
      if (e < 7)       check_output("both_wait", {2'b11, tick_model(e), 2'b00});
      else if (e == 7) check_output("both_edge", {2'b00, tick_model(e), 2'b11});
      else             check_output("both_tick", {2'b00, tick_model(e), 2'b00});
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
